rptr_empty: RTL and testbench
=============================

// Module: rptr_empty
// PURPOSE
//  Read-side pointer and status controller for the dual-clock FIFO. Lives wholly in the read clock domain.
//  - Advances the binary read pointer and Gray read pointer on each accepted read.
//  - Drives the memory read address.
//  - Compares the next Gray read pointer with the synchronised Gray write pointer (rq2_wptr) to flag empty.
//  - rptr is exported to the write domain through the read-to-write synchroniser.
// PARAMETERS
//  ADDRSIZE   4  FIFO address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
//  AE_THRESH  2  almost-empty threshold in entries; raempty asserts when level <= AE_THRESH (RPTR_LEVEL_EN only).
// PORTS
//  rclk      in   1           read clock
//  rrst_n    in   1           asynchronous active-low reset, read domain
//  rinc      in   1           read request; accepted only when rempty==0
//  rq2_wptr  in   ADDRSIZE+1  Gray write pointer, already 2-flop synchronised to rclk
//  raddr     out  ADDRSIZE    memory read address = rbin[ADDRSIZE-1:0]
//  rptr      out  ADDRSIZE+1  registered Gray read pointer (to write-domain synchroniser)
//  rempty    out  1           FIFO empty, registered
//  rerr      out  1           sticky underflow error, registered
//  raempty   out  1           almost empty, registered
//  rlevel    out  ADDRSIZE+1  occupancy 0..2**ADDRSIZE, registered (port exists only with RPTR_LEVEL_EN)
// BEHAVIOUR
//  Reset (async, rrst_n low):
//   - rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rerr=0, rlevel=0.
//   - All outputs hold these values while rrst_n is low.
//  Pointer update:
//   - rd_ok = rinc & ~rempty.
//   - rbinnext = rbin + rd_ok, modulo 2**(ADDRSIZE+1).
//   - rgraynext = (rbinnext>>1) ^ rbinnext.
//   - rbin<=rbinnext and rptr<=rgraynext on every rclk edge.
//   - raddr is combinational from the rbin register only; no combinational path from rinc.
//   - Read data for an address presented in cycle N is consumed by the memory in cycle N.
//  Empty:
//   - rempty <= (rgraynext == rq2_wptr), so it updates on the same edge as rptr.
//   - A read that takes the last entry sets rempty on that edge.
//   - A change on rq2_wptr clears rempty on the next rclk edge.
//   - Total write-to-empty-clear latency is 3 rclk edges (2 synchroniser + 1).
//  Wrap-around:
//   - The extra pointer MSB distinguishes laps.
//   - rbin 2**(ADDRSIZE+1)-1 -> 0 is legal and continuous.
//   - Empty compare is valid across the wrap.
//  Underflow: rinc=1 while rempty=1 means:
//   - Pointers hold.
//   - rerr<=1 on that edge; rerr stays set until reset.
//  Simultaneous events:
//   - rinc with rq2_wptr changing in the same cycle: both are applied.
//   - rempty reflects rgraynext against the new rq2_wptr.
//  Reset mid-operation: immediately returns to the reset values; no read is accepted while rrst_n is low.
//  rq2_wptr is treated as Gray-coded; at most 1 bit changes per rclk.
// CONFIGURATION
//  Macro: RPTR_LEVEL_EN.
//  Defined:
//   - wbin = Gray-to-binary(rq2_wptr) via XOR prefix.
//   - lvl_next = (wbin - rbinnext) mod 2**(ADDRSIZE+1).
//   - rlevel <= lvl_next.
//   - raempty <= (lvl_next <= AE_THRESH).
//  Not defined:
//   - No Gray-to-binary logic and no rlevel port.
//   - raempty is driven equal to rempty.
// TESTING (ADDRSIZE=4, AE_THRESH=2)
//  1. Reset with rq2_wptr=0 -> rempty=1, raempty=1, raddr=0, rptr=0, rerr=0.
//  2. rq2_wptr walks Gray 0..5 (binary 5 written), then 5 reads:
//     - rempty=0 one edge after the first change.
//     - raddr steps 0..4; rptr Gray sequence 1,3,2,6,7.
//     - rempty=1 on the 5th read edge.
//  3. rinc=1 with rempty=1 -> rptr unchanged; rerr=1 next edge and stays 1 for 10 more cycles.
//  4. Wrap-around: run 40 writes/reads through the pointers.
//     - rbin passes 31->0 and raddr 15->0.
//     - rempty correct throughout; no spurious rerr.
//  5. RPTR_LEVEL_EN, wbin=16, rbin=0 -> rlevel=16.
//     - Read to level 3: raempty=0.
//     - Next read gives level 2: raempty=1 on that edge.
//  6. rrst_n pulsed low mid-burst with level 6 -> all outputs return to reset values asynchronously.
//     - Reads resume from raddr=0 after release.

Source files
------------

// File: rtl/rptr_empty.sv
// Read-side pointer and empty/underflow status for a dual-clock FIFO (rclk domain).
// Latency: all status outputs registered; rempty updates on the same edge as rptr.
// Backpressure: a read is accepted only while not empty; a read on empty sets sticky rerr.
// Optional feature macro: RPTR_LEVEL_EN adds the rlevel port and level-based raempty.
module rptr_empty #(
  parameter int ADDRSIZE  = 4
`ifdef RPTR_LEVEL_EN
  , parameter int AE_THRESH = 2
`endif
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                rerr,
  output logic                raempty
`ifdef RPTR_LEVEL_EN
  , output logic [ADDRSIZE:0] rlevel
`endif
);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic              rempty_q, rempty_d;
  logic              rerr_q, rerr_d;
  logic              rd_ok;

  // Next pointers, empty compare against the synchronised write pointer, sticky underflow.
  always_comb begin
    rd_ok    = rinc & ~rempty_q;
    rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, rd_ok};
    rptr_d   = (rbin_d >> 1) ^ rbin_d;
    rempty_d = (rptr_d == rq2_wptr);
    rerr_d   = rerr_q | (rinc & rempty_q);
  end

  // Pointer and status registers; reset leaves the FIFO empty with no error.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rerr_q   <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rerr_q   <= rerr_d;
    end
  end

  // Memory address comes straight from the binary register, never from rinc.
  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rptr   = rptr_q;
  assign rempty = rempty_q;
  assign rerr   = rerr_q;

`ifdef RPTR_LEVEL_EN
  localparam logic [ADDRSIZE:0] AE_T = (ADDRSIZE+1)'(AE_THRESH);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic              raempty_q, raempty_d;

  // Gray-to-binary of the write pointer (XOR of all bits at and above each position), then occupancy.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
    rlevel_d  = wbin - rbin_d;
    raempty_d = (rlevel_d <= AE_T);
  end

  // Level and almost-empty registers, updated on the same edge as the pointers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel_q  <= '0;
      raempty_q <= 1'b1;
    end else begin
      rlevel_q  <= rlevel_d;
      raempty_q <= raempty_d;
    end
  end

  assign rlevel  = rlevel_q;
  assign raempty = raempty_q;
`else
  assign raempty = rempty_q;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
module tb_rptr_empty;

  localparam int AW = 4;
  localparam int AE = 2;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rinc;
  logic [AW:0]   rq2_wptr;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          rerr;
  logic          raempty;
`ifdef RPTR_LEVEL_EN
  logic [AW:0]   rlevel;
`endif

  rptr_empty #(.ADDRSIZE(AW)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rinc     (rinc),
    .rq2_wptr (rq2_wptr),
    .raddr    (raddr),
    .rptr     (rptr),
    .rempty   (rempty),
    .rerr     (rerr),
    .raempty  (raempty)
`ifdef RPTR_LEVEL_EN
    , .rlevel (rlevel)
`endif
  );

  always #5 rclk = ~rclk;

  typedef struct {
    int raddr;
    int rptr;
    int empty;
    int err;
    int aempty;
    int level;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: plain counts of entries written and read since reset.
  int  wr_cnt;
  int  rd_cnt;
  bit  m_empty;
  bit  m_err;

  function automatic int gray(input int v);
    int b;
    b = v % 32;
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_raddr"},   int'(raddr),   0);
    check({tag, "_rptr"},    int'(rptr),    0);
    check({tag, "_rempty"},  int'(rempty),  1);
    check({tag, "_raempty"}, int'(raempty), 1);
    check({tag, "_rerr"},    int'(rerr),    0);
`ifdef RPTR_LEVEL_EN
    check({tag, "_rlevel"},  int'(rlevel),  0);
`endif
  endtask

  // One cycle of stimulus: optional write (seen through the synchroniser) and optional read request.
  task automatic step(input bit rd_req, input bit wr_inc);
    exp_t e;
    int   lvl;
    @(negedge rclk);
    if (wr_inc && (wr_cnt - rd_cnt) < 16) wr_cnt++;
    rinc     = rd_req;
    rq2_wptr = (AW+1)'(gray(wr_cnt));
    if (rd_req) begin
      if (m_empty) m_err = 1'b1;
      else         rd_cnt++;
    end
    m_empty  = (rd_cnt == wr_cnt);
    lvl      = wr_cnt - rd_cnt;
    e.raddr  = rd_cnt % 16;
    e.rptr   = gray(rd_cnt);
    e.empty  = int'(m_empty);
    e.err    = int'(m_err);
    e.level  = lvl;
`ifdef RPTR_LEVEL_EN
    e.aempty = (lvl <= AE) ? 1 : 0;
`else
    e.aempty = int'(m_empty);
`endif
    q.push_back(e);
  endtask

  // Pulse reset between edges, confirm outputs drop at once and hold while rinc is pressed.
  task automatic do_reset(input string tag);
    @(posedge rclk);
    #3;
    rrst_n = 1'b0;
    #1;
    check_reset_vals({tag, "_async"});
    rinc = 1'b1;
    repeat (2) @(posedge rclk);
    #1;
    check_reset_vals({tag, "_held"});
    @(negedge rclk);
    rinc     = 1'b0;
    rq2_wptr = '0;
    rrst_n   = 1'b1;
    wr_cnt   = 0;
    rd_cnt   = 0;
    m_empty  = 1'b1;
    m_err    = 1'b0;
  endtask

  // Monitor: compares every registered output update against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge rclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("raddr",   int'(raddr),   e.raddr);
        check("rptr",    int'(rptr),    e.rptr);
        check("rempty",  int'(rempty),  e.empty);
        check("rerr",    int'(rerr),    e.err);
        check("raempty", int'(raempty), e.aempty);
`ifdef RPTR_LEVEL_EN
        check("rlevel",  int'(rlevel),  e.level);
`endif
      end
    end
  end

  initial begin
    int wait_cyc;
    rrst_n   = 1'b0;
    rinc     = 1'b0;
    rq2_wptr = '0;
    wr_cnt   = 0;
    rd_cnt   = 0;
    m_empty  = 1'b1;
    m_err    = 1'b0;
    #12;
    check_reset_vals("por");
    @(negedge rclk);
    rrst_n = 1'b1;

    // Five writes arrive, then five reads drain them, then reads on empty.
    repeat (5)  step(1'b0, 1'b1);
    repeat (5)  step(1'b1, 1'b0);
    repeat (11) step(1'b1, 1'b0);

    // Fill to full depth and drain completely.
    do_reset("r1");
    repeat (16) step(1'b0, 1'b1);
    repeat (16) step(1'b1, 1'b0);

    // Random traffic without underflow: many laps across the pointer wrap.
    do_reset("r2");
    for (int i = 0; i < 250; i++) begin
      step(bit'($urandom_range(0, 1)) && !m_empty, bit'($urandom_range(0, 2) != 0));
    end

    // Fully random traffic including reads on empty.
    do_reset("r3");
    for (int i = 0; i < 150; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // Build level 6, keep a read/write burst going, reset mid-burst, then resume.
    do_reset("r4");
    repeat (6) step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    do_reset("r5");
    repeat (3) step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge rclk);
      wait_cyc++;
    end
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
